// File: rtl/pipe_buf_stage_if.sv
// Handshake bundle for one pipe_buf_stage: upstream push side, downstream pop side,
// the squash input and the occupancy status.
// Ports: master drives in_valid/in_data/flush/out_ready; slave (the stage) drives the rest.
interface pipe_buf_stage_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // The buffer stage itself.
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_buf_stage.sv
// Purpose: reusable pipeline register / small FIFO (1..4 entries) with flush and NOP fill.
// Latency: 1 cycle when empty; otherwise strict FIFO order behind older entries.
// Backpressure: in_ready drops when full (unless READY_PASS and out_ready); out_data holds while !out_ready.
// Ports: clk, reset (async, active-low), bus (slave modport: in_valid/in_ready/in_data,
//        flush, out_valid/out_ready/out_data, occupancy).
module pipe_buf_stage #(
  parameter int          WIDTH      = 32,
  parameter int          DEPTH      = 1,
  parameter bit          READY_PASS = 1'b1,
  parameter logic [31:0] NOP_VALUE  = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  pipe_buf_stage_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Bubble payload, zero-extended or truncated to the payload width.
  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VALUE);

  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic full;
  logic not_empty;
  logic push;
  logic pop;

  // Wrap by explicit compare so non-power-of-two depths cycle correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    not_empty = (count_q != '0);
    // READY_PASS lets a full stage accept when the head leaves in the same cycle.
    bus.in_ready  = !full || (READY_PASS && bus.out_ready);
    bus.out_valid = not_empty;
    // Output depends only on registered state: no in_* to out_* comb path.
    bus.out_data  = not_empty ? mem_q[rd_ptr_q] : NOP_W;
    bus.occupancy = count_q;

    push = bus.in_valid && bus.in_ready;
    pop  = not_empty && bus.out_ready;

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;

    if (bus.flush) begin
      // Squash wins over any same-cycle push or pop.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        // With DEPTH=1 and push&pop, wr_ptr==rd_ptr so the head is replaced.
        mem_d[wr_ptr_q] = bus.in_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is not reset: contents are only visible through count/rd_ptr.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_pipe_buf_stage.sv
module tb_pipe_buf_stage;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  pipe_buf_stage_if #(.WIDTH(32), .DEPTH(2)) b2 ();
  pipe_buf_stage_if #(.WIDTH(32), .DEPTH(3)) b3 ();
  pipe_buf_stage_if #(.WIDTH(32), .DEPTH(1)) b1 ();

  pipe_buf_stage #(.WIDTH(32), .DEPTH(2), .READY_PASS(1'b0)) u_d2 (.clk(clk), .reset(reset), .bus(b2));
  pipe_buf_stage #(.WIDTH(32), .DEPTH(3), .READY_PASS(1'b0)) u_d3 (.clk(clk), .reset(reset), .bus(b3));
  pipe_buf_stage #(.WIDTH(32), .DEPTH(1), .READY_PASS(1'b1)) u_d1 (.clk(clk), .reset(reset), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0] iv_pat;
    logic [39:0] or_pat;
    int exp_cnt;
    int wr_k;
    int rd_k;
    int max_cnt;
    logic p_push;
    logic p_pop;

    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.flush = 1'b0; b2.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.flush = 1'b0; b3.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.flush = 1'b0; b1.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, b2.out_valid}, 32'd0);
    chk("rst_out_data",  b2.out_data, 32'h13);
    chk("rst_occupancy", {30'd0, b2.occupancy}, 32'd0);
    chk("rst_in_ready",  {31'd0, b2.in_ready}, 32'd1);
    chk("rst_d1_in_ready", {31'd0, b1.in_ready}, 32'd1);
    reset = 1'b1;
    tick();

    // Streaming, DEPTH=2, READY_PASS=0
    for (int k = 1; k <= 4; k++) begin
      b2.in_valid = 1'b1; b2.in_data = 32'(k); b2.out_ready = 1'b1;
      tick();
      chk("stream_valid", {31'd0, b2.out_valid}, 32'd1);
      chk("stream_data",  b2.out_data, 32'(k));
      chk("stream_occ",   {30'd0, b2.occupancy}, 32'd1);
    end
    b2.in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", {31'd0, b2.out_valid}, 32'd0);
    chk("stream_drain_data",  b2.out_data, 32'h13);

    // Backpressure
    b2.out_ready = 1'b0;
    b2.in_valid = 1'b1; b2.in_data = 32'hA;
    tick();
    chk("bp_ready_1", {31'd0, b2.in_ready}, 32'd1);
    chk("bp_head_1",  b2.out_data, 32'hA);
    b2.in_data = 32'hB;
    tick();
    chk("bp_ready_2", {31'd0, b2.in_ready}, 32'd0);
    chk("bp_occ_2",   {30'd0, b2.occupancy}, 32'd2);
    b2.in_data = 32'hC;
    tick();
    chk("bp_hold_data", b2.out_data, 32'hA);
    chk("bp_hold_occ",  {30'd0, b2.occupancy}, 32'd2);
    b2.out_ready = 1'b1;
    #1;
    chk("bp_rel_a", b2.out_data, 32'hA);
    tick();
    chk("bp_rel_b", b2.out_data, 32'hB);
    chk("bp_rel_b_occ", {30'd0, b2.occupancy}, 32'd1);
    tick();
    chk("bp_rel_c", b2.out_data, 32'hC);
    chk("bp_rel_c_valid", {31'd0, b2.out_valid}, 32'd1);
    b2.in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'd0, b2.out_valid}, 32'd0);

    // Flush with same-cycle push and pop
    b2.out_ready = 1'b0;
    b2.in_valid = 1'b1; b2.in_data = 32'hA;
    tick();
    b2.in_data = 32'hB;
    tick();
    chk("fl_full_occ", {30'd0, b2.occupancy}, 32'd2);
    b2.flush = 1'b1; b2.in_data = 32'hC; b2.out_ready = 1'b1;
    tick();
    chk("fl_valid", {31'd0, b2.out_valid}, 32'd0);
    chk("fl_data",  b2.out_data, 32'h13);
    chk("fl_occ",   {30'd0, b2.occupancy}, 32'd0);
    b2.flush = 1'b0; b2.in_valid = 1'b0;
    tick();
    chk("fl_no_c_valid", {31'd0, b2.out_valid}, 32'd0);
    chk("fl_no_c_data",  b2.out_data, 32'h13);

    // Reset mid-stream, asynchronous
    b2.out_ready = 1'b0;
    b2.in_valid = 1'b1; b2.in_data = 32'hA;
    tick();
    b2.in_data = 32'hB;
    tick();
    b2.in_valid = 1'b0;
    chk("mr_occ_before", {30'd0, b2.occupancy}, 32'd2);
    #3;
    reset = 1'b0;
    #1;
    chk("mr_valid",    {31'd0, b2.out_valid}, 32'd0);
    chk("mr_data",     b2.out_data, 32'h13);
    chk("mr_occ",      {30'd0, b2.occupancy}, 32'd0);
    chk("mr_in_ready", {31'd0, b2.in_ready}, 32'd1);
    #3;
    reset = 1'b1;
    tick();

    // Wrap, DEPTH=3, irregular valid/ready patterns
    iv_pat  = 40'hB6_DF7F_EDFF;
    or_pat  = 40'h5A_D6B5_3A70;
    exp_cnt = 0;
    wr_k    = 0;
    rd_k    = 0;
    max_cnt = 0;
    for (int cyc = 0; cyc < 80 && rd_k < 10; cyc++) begin
      b3.in_valid  = (wr_k < 10) && iv_pat[cyc % 40];
      b3.in_data   = 32'h100 + 32'(wr_k);
      b3.out_ready = (cyc < 40) ? or_pat[cyc] : 1'b1;
      #1;
      chk("wr_occ",   {30'd0, b3.occupancy}, 32'(exp_cnt));
      chk("wr_ready", {31'd0, b3.in_ready}, {31'd0, exp_cnt < 3});
      chk("wr_valid", {31'd0, b3.out_valid}, {31'd0, exp_cnt > 0});
      if (exp_cnt > 0) begin
        chk("wr_data", b3.out_data, 32'h100 + 32'(rd_k));
      end
      p_push = b3.in_valid && (exp_cnt < 3);
      p_pop  = b3.out_ready && (exp_cnt > 0);
      tick();
      if (p_push) begin wr_k++; exp_cnt++; end
      if (p_pop)  begin rd_k++; exp_cnt--; end
      if (exp_cnt > max_cnt) max_cnt = exp_cnt;
    end
    b3.in_valid  = 1'b0;
    b3.out_ready = 1'b0;
    chk("wr_all_read", 32'(rd_k), 32'd10);
    chk("wr_reached_full", 32'(max_cnt), 32'd3);
    #1;
    chk("wr_end_valid", {31'd0, b3.out_valid}, 32'd0);

    // Pass-through when full, DEPTH=1, READY_PASS=1
    b1.in_valid = 1'b1; b1.in_data = 32'h5; b1.out_ready = 1'b0;
    tick();
    chk("pt_head",     b1.out_data, 32'h5);
    chk("pt_full_rdy", {31'd0, b1.in_ready}, 32'd0);
    b1.in_data = 32'h6; b1.out_ready = 1'b1;
    #1;
    chk("pt_pass_rdy", {31'd0, b1.in_ready}, 32'd1);
    tick();
    chk("pt_next_data",  b1.out_data, 32'h6);
    chk("pt_next_occ",   {30'd0, b1.occupancy}, 32'd1);
    chk("pt_next_valid", {31'd0, b1.out_valid}, 32'd1);
    b1.in_valid = 1'b0;
    tick();
    chk("pt_drain_valid", {31'd0, b1.out_valid}, 32'd0);
    chk("pt_drain_data",  b1.out_data, 32'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
